// File: rtl/key_entry_pkg.sv
//----------------------------------------------------------------------------
// key_entry_pkg : FSM state encoding and command codes for key_entry.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

package key_entry_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      ACT      = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   localparam logic [4:0] CMD_BKSP  = 5'd16;
   localparam logic [4:0] CMD_CLR   = 5'd17;
   localparam logic [4:0] CMD_ENTER = 5'd18;

endpackage

`default_nettype wire

// File: rtl/key_sync.sv
//----------------------------------------------------------------------------
// key_sync : parameterized-width two-flop synchronizer, async active-low reset.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module key_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/key_entry.sv
//----------------------------------------------------------------------------
// key_entry : debounced push-button to hex-entry register with edit/commit.
// Optional macro KEY_ENTRY_SYNC_EN adds a two-flop input synchronizer.
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module key_entry
   import key_entry_pkg::*;
#(
   parameter int DIGITS       = 8,
   parameter int DEBOUNCE_CYC = 3
) (
   input  logic                         hz100,
   input  logic                         nrst,
   input  logic [4:0]                   code,
   input  logic                         strobe,
   output logic [4*DIGITS-1:0]          value,
   output logic [$clog2(DIGITS+1)-1:0]  ndigits,
   output logic                         full,
   output logic [4*DIGITS-1:0]          result,
   output logic                         result_valid
);

   localparam int         NW   = $clog2(DIGITS+1);
   localparam logic [3:0] DC_C = 4'(DEBOUNCE_CYC);

   logic [4:0] s_code;
   logic       s_strobe;

`ifdef KEY_ENTRY_SYNC_EN
   logic [5:0] sync_out;

   key_sync #(.WIDTH(6)) u_sync (
      .clk_i  (hz100),
      .rst_ni (nrst),
      .d_i    ({code, strobe}),
      .q_o    (sync_out)
   );

   assign s_code   = sync_out[5:1];
   assign s_strobe = sync_out[0];
`else
   assign s_code   = code;
   assign s_strobe = strobe;
`endif

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [4:0]        key_q, key_d;
   logic [4*DIGITS-1:0] value_q, value_d;
   logic [NW-1:0]     nd_q, nd_d;
   logic [4*DIGITS-1:0] result_q, result_d;
   logic              valid_q, valid_d;

   logic [4*DIGITS+3:0] shift_cat;
   logic [3:0]          cnt_inc;
   logic                full_w;

   assign shift_cat = {value_q, key_q[3:0]};
   assign cnt_inc   = cnt_q + 4'd1;
   assign full_w    = (nd_q == NW'(DIGITS));

   always_ff @(posedge hz100 or negedge nrst) begin
      if (!nrst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         key_q    <= '0;
         value_q  <= '0;
         nd_q     <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         key_q    <= key_d;
         value_q  <= value_d;
         nd_q     <= nd_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      unique case (state_q)
         IDLE: begin
            if (s_strobe) begin
               key_d   = s_code;
               cnt_d   = 4'd1;
               state_d = (DC_C == 4'd1) ? ACT : DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (!s_strobe) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else if (s_code != key_q) begin
               key_d = s_code;
               cnt_d = 4'd1;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == DC_C) state_d = ACT;
            end
         end
         ACT: begin
            cnt_d   = '0;
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            // Any press sample restarts the release count, so holding never repeats.
            if (s_strobe) begin
               cnt_d = '0;
            end else if (cnt_inc == DC_C) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      value_d  = value_q;
      nd_d     = nd_q;
      result_d = result_q;
      valid_d  = 1'b0;
      if (state_q == ACT) begin
         if (!key_q[4]) begin
            if (!full_w) begin
               value_d = shift_cat[4*DIGITS-1:0];
               nd_d    = nd_q + NW'(1);
            end
         end else begin
            case (key_q)
               CMD_BKSP: begin
                  if (nd_q != '0) begin
                     value_d = value_q >> 4;
                     nd_d    = nd_q - NW'(1);
                  end
               end
               CMD_CLR: begin
                  value_d = '0;
                  nd_d    = '0;
               end
               CMD_ENTER: begin
                  result_d = value_q;
                  valid_d  = 1'b1;
                  value_d  = '0;
                  nd_d     = '0;
               end
               default: ;
            endcase
         end
      end
   end

   assign value        = value_q;
   assign ndigits      = nd_q;
   assign full         = full_w;
   assign result       = result_q;
   assign result_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_key_entry.sv
//----------------------------------------------------------------------------
// tb_key_entry : directed table-driven bench for key_entry (default parameters).
// Revision 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_key_entry;

   localparam int DC = 3;
`ifdef KEY_ENTRY_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   localparam int REL = DC + LAT + 2;

   logic        hz100 = 1'b0;
   logic        nrst;
   logic [4:0]  code;
   logic        strobe;
   logic [31:0] value;
   logic [3:0]  ndigits;
   logic        full;
   logic [31:0] result;
   logic        result_valid;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   key_entry #(.DIGITS(8), .DEBOUNCE_CYC(DC)) dut (
      .hz100        (hz100),
      .nrst         (nrst),
      .code         (code),
      .strobe       (strobe),
      .value        (value),
      .ndigits      (ndigits),
      .full         (full),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 hz100 = ~hz100;

   always @(negedge hz100) if (result_valid) pulses++;

   typedef struct {
      logic [4:0]  code;
      int          hold;
      logic [31:0] val;
      int          nd;
      logic        full;
      logic [31:0] res;
      int          pulses;
   } vec_t;

   vec_t vecs[40];
   int   nv = 0;

   function automatic void add(logic [4:0] c, int h, logic [31:0] v, int n,
                               logic f, logic [31:0] r, int p);
      vecs[nv] = '{c, h, v, n, f, r, p};
      nv++;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic key(logic [4:0] c, int hold);
      @(negedge hz100);
      code   = c;
      strobe = 1'b1;
      repeat (hold) @(negedge hz100);
      strobe = 1'b0;
      repeat (REL) @(negedge hz100);
   endtask

   task automatic chk_state(string tag, logic [31:0] v, int n, logic f, logic [31:0] r);
      chk({tag, ".value"},   value, v);
      chk({tag, ".ndigits"}, 32'(ndigits), 32'(n));
      chk({tag, ".full"},    32'(full), 32'(f));
      chk({tag, ".result"},  result, r);
   endtask

   initial begin
      // 0-15 digits, 16 BKSP, 17 CLR, 18 ENTER, 19 no-op
      add(5'd5,  6, 32'h5,        1, 0, 32'h0,    0);
      add(5'd10, 6, 32'h5A,       2, 0, 32'h0,    0);
      add(5'd7,  2, 32'h5A,       2, 0, 32'h0,    0);
      add(5'd17, 4, 32'h0,        0, 0, 32'h0,    0);
      add(5'd1,  3, 32'h1,        1, 0, 32'h0,    0);
      add(5'd1,  3, 32'h11,       2, 0, 32'h0,    0);
      add(5'd1,  3, 32'h111,      3, 0, 32'h0,    0);
      add(5'd1,  3, 32'h1111,     4, 0, 32'h0,    0);
      add(5'd1,  3, 32'h11111,    5, 0, 32'h0,    0);
      add(5'd1,  3, 32'h111111,   6, 0, 32'h0,    0);
      add(5'd1,  3, 32'h1111111,  7, 0, 32'h0,    0);
      add(5'd1,  3, 32'h11111111, 8, 1, 32'h0,    0);
      add(5'd1,  3, 32'h11111111, 8, 1, 32'h0,    0);
      add(5'd16, 3, 32'h1111111,  7, 0, 32'h0,    0);
      add(5'd17, 3, 32'h0,        0, 0, 32'h0,    0);
      add(5'd1,  4, 32'h1,        1, 0, 32'h0,    0);
      add(5'd2,  4, 32'h12,       2, 0, 32'h0,    0);
      add(5'd3,  4, 32'h123,      3, 0, 32'h0,    0);
      add(5'd16, 4, 32'h12,       2, 0, 32'h0,    0);
      add(5'd17, 4, 32'h0,        0, 0, 32'h0,    0);
      add(5'd16, 4, 32'h0,        0, 0, 32'h0,    0);
      add(5'd11, 4, 32'hB,        1, 0, 32'h0,    0);
      add(5'd14, 4, 32'hBE,       2, 0, 32'h0,    0);
      add(5'd14, 4, 32'hBEE,      3, 0, 32'h0,    0);
      add(5'd15, 4, 32'hBEEF,     4, 0, 32'h0,    0);
      add(5'd18, 4, 32'h0,        0, 0, 32'hBEEF, 1);
      add(5'd18, 4, 32'h0,        0, 0, 32'h0,    1);
      add(5'd9,  4, 32'h9,        1, 0, 32'h0,    0);
      add(5'd19, 5, 32'h9,        1, 0, 32'h0,    0);
      add(5'd17, 3, 32'h0,        0, 0, 32'h0,    0);

      nrst   = 1'b0;
      code   = '0;
      strobe = 1'b0;
      repeat (2) @(negedge hz100);
      chk_state("reset", 32'h0, 0, 1'b0, 32'h0);
      chk("reset.result_valid", 32'(result_valid), 32'h0);
      nrst = 1'b1;

      for (int i = 0; i < nv; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         pulses = 0;
         key(vecs[i].code, vecs[i].hold);
         chk_state(tag, vecs[i].val, vecs[i].nd, vecs[i].full, vecs[i].res);
         chk({tag, ".pulses"}, 32'(pulses), 32'(vecs[i].pulses));
      end

      // Exact update edge relative to first strobe capture
      @(negedge hz100);
      code   = 5'd5;
      strobe = 1'b1;
      repeat (DC + LAT) @(negedge hz100);
      chk("timing.early", value, 32'h0);
      @(negedge hz100);
      chk("timing.ontime", value, 32'h5);
      strobe = 1'b0;
      repeat (REL) @(negedge hz100);

      // Code change mid-debounce: only the second code is entered
      @(negedge hz100);
      code   = 5'd7;
      strobe = 1'b1;
      repeat (2) @(negedge hz100);
      code = 5'd8;
      repeat (4) @(negedge hz100);
      strobe = 1'b0;
      repeat (REL) @(negedge hz100);
      chk_state("change", 32'h58, 2, 1'b0, 32'h0);

      pulses = 0;
      key(5'd3, 50);
      chk_state("hold50", 32'h583, 3, 1'b0, 32'h0);

      pulses = 0;
      key(5'd18, 3);
      chk_state("enter583", 32'h0, 0, 1'b0, 32'h583);
      chk("enter583.pulses", 32'(pulses), 32'd1);
      key(5'd9, 3);
      chk("pre_rst.value", value, 32'h9);

      // Async reset mid-debounce, then the still-held key is a fresh press
      @(negedge hz100);
      code   = 5'd4;
      strobe = 1'b1;
      repeat (2) @(negedge hz100);
      #3 nrst = 1'b0;
      #1;
      chk_state("midrst", 32'h0, 0, 1'b0, 32'h0);
      chk("midrst.result_valid", 32'(result_valid), 32'h0);
      @(negedge hz100);
      nrst   = 1'b1;
      pulses = 0;
      repeat (DC + LAT) @(negedge hz100);
      chk("postrst.early", value, 32'h0);
      @(negedge hz100);
      chk("postrst.value", value, 32'h4);
      chk("postrst.ndigits", 32'(ndigits), 32'd1);
      strobe = 1'b0;
      repeat (REL) @(negedge hz100);
      chk("postrst.pulses", 32'(pulses), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
